// File: rtl/reg_list_decoder_seq_pkg.sv
// Shared definitions for the sequencing register write-enable decoder.
package reg_list_decoder_seq_pkg;

    // Default register address width; the enable count is always 2**ADDR_W.
    localparam int ADDR_W_DEF = 4;

    // Operation sequencer states.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_e;

endpackage : reg_list_decoder_seq_pkg

// File: rtl/reg_list_decoder_seq_prio_enc_dir.sv
// Directional priority encoder: lowest set bit for dir=0, highest for dir=1.
module prio_enc_dir
    import reg_list_decoder_seq_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    localparam int NREGS = 2 ** ADDR_W
) (
    input  logic [NREGS-1:0]  mask,
    input  logic              dir,
    output logic [ADDR_W-1:0] index,
    output logic              valid
);

    // Scan so that the winning bit is the last one written.
    always_comb begin
        // NOTE: every output gets a default before the loops; otherwise a path
        // that assigns nothing would infer a latch.
        index = '0;
        valid = |mask;
        if (!dir) begin
            for (int i = NREGS - 1; i >= 0; i--) begin
                if (mask[i]) index = ADDR_W'(i);
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (mask[i]) index = ADDR_W'(i);
            end
        end
    end

endmodule : prio_enc_dir

// File: rtl/reg_list_decoder_seq.sv
// Sequencing register write-enable decoder: single-register decode or
// LDM/STM-style list walk, one one-hot enable per accepted step.
module reg_list_decoder_seq
    import reg_list_decoder_seq_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    localparam int NREGS = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              list_mode,
    input  logic              dir,
    input  logic [ADDR_W-1:0] addr,
    input  logic [NREGS-1:0]  reg_list,
    input  logic              L,
    input  logic              step,
    output logic [NREGS-1:0]  E,
    output logic [ADDR_W-1:0] idx,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   count
);

    state_e              state_q, state_d;
    logic [NREGS-1:0]    mask_q,  mask_d;
    logic                dir_q,   dir_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [NREGS-1:0]    e_q,     e_d;
    logic [ADDR_W-1:0]   idx_q,   idx_d;

    logic [ADDR_W-1:0]   cur_idx, nxt_idx;
    logic                cur_valid, nxt_valid;

    // Register currently presented: drives mask clearing on an accepted step.
    prio_enc_dir #(.ADDR_W(ADDR_W)) u_cur_enc (
        .mask  (mask_q),
        .dir   (dir_q),
        .index (cur_idx),
        .valid (cur_valid)
    );

    // Register to present next cycle: feeds the registered enable output.
    prio_enc_dir #(.ADDR_W(ADDR_W)) u_nxt_enc (
        .mask  (mask_d),
        .dir   (dir_d),
        .index (nxt_idx),
        .valid (nxt_valid)
    );

    // Next-state logic: capture on start, retire one mask bit per accepted step.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        dir_d   = dir_q;
        count_d = count_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    dir_d   = dir;
                    count_d = '0;
                    mask_d  = list_mode ? reg_list : (NREGS'(1) << addr);
                    state_d = (mask_d != '0) ? S_RUN : S_FIN;
                end
            end
            S_RUN: begin
                // A step while L is low is not an acceptance.
                if (step && L && cur_valid) begin
                    mask_d  = mask_q & ~(NREGS'(1) << cur_idx);
                    count_d = count_q + (ADDR_W + 1)'(1);
                    if (mask_d == '0) state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                mask_d  = '0;
            end
        endcase
    end

    // Enable output: one-hot of the next presented register, gated by L.
    always_comb begin
        e_d   = '0;
        idx_d = '0;
        if (state_d == S_RUN && L && nxt_valid) begin
            e_d   = NREGS'(1) << nxt_idx;
            idx_d = nxt_idx;
        end
    end

    // State, mask, count and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            state_q <= S_IDLE;
            mask_q  <= '0;
            dir_q   <= 1'b0;
            count_q <= '0;
            e_q     <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            dir_q   <= dir_d;
            count_q <= count_d;
            e_q     <= e_d;
            idx_q   <= idx_d;
        end
    end

    assign E     = e_q;
    assign idx   = idx_q;
    assign busy  = (state_q == S_RUN);
    assign done  = (state_q == S_FIN);
    assign count = count_q;

endmodule : reg_list_decoder_seq

// File: tb/tb_reg_list_decoder_seq.sv
// Self-checking bench: stimulus pushes expected register sequences into a
// scoreboard queue; a negedge monitor pops and compares as the DUT presents.
module tb_reg_list_decoder_seq;

    localparam int ADDR_W = 4;
    localparam int NREGS  = 16;

    logic              clk = 1'b0;
    logic              reset, start, list_mode, dir, L, step;
    logic [ADDR_W-1:0] addr;
    logic [NREGS-1:0]  reg_list;
    logic [NREGS-1:0]  E;
    logic [ADDR_W-1:0] idx;
    logic              busy, done;
    logic [ADDR_W:0]   count;

    reg_list_decoder_seq dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .list_mode (list_mode),
        .dir       (dir),
        .addr      (addr),
        .reg_list  (reg_list),
        .L         (L),
        .step      (step),
        .E         (E),
        .idx       (idx),
        .busy      (busy),
        .done      (done),
        .count     (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_done;
        int val;     // register index, or final count for a done token
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic l_edge = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: registers visited in scan order, then a done token carrying the total.
    task automatic push_expect(input bit lm, input bit d, input int a, input logic [NREGS-1:0] lst);
        int regs[$];
        exp_t t;
        for (int i = 0; i < NREGS; i++) begin
            if (lm ? (lst[i] === 1'b1) : (i == a)) regs.push_back(i);
        end
        if (d) regs.reverse();
        foreach (regs[k]) begin
            t.is_done = 1'b0;
            t.val = regs[k];
            exp_q.push_back(t);
        end
        t.is_done = 1'b1;
        t.val = regs.size();
        exp_q.push_back(t);
    endtask

    // L value sampled by the DUT at the most recent edge.
    always @(posedge clk) l_edge <= L;

    // Monitor.
    always @(negedge clk) begin
        if (!reset) begin
            if ($countones(E) > 1) check("e_onehot", 32'(E), 32'(1) << idx);
            if (!l_edge && E != '0) check("e_gated_by_l", 32'(E), 32'd0);
            if (E == '0 && idx != '0) check("idx_zero_when_e_zero", 32'(idx), 32'd0);
            if (E != '0 || (busy && step && L)) begin
                if (exp_q.size() == 0 || exp_q[0].is_done) begin
                    check("sb_unexpected_enable", 32'(E), 32'd0);
                end else begin
                    if (E != '0) begin
                        check("e_value", 32'(E), 32'(1) << exp_q[0].val);
                        check("idx_value", 32'(idx), 32'(exp_q[0].val));
                    end
                    if (busy && step && L) void'(exp_q.pop_front());
                end
            end
            if (done) begin
                check("done_not_busy", 32'(busy), 32'd0);
                if (exp_q.size() == 0 || !exp_q[0].is_done) begin
                    check("sb_unexpected_done", 32'd1, 32'd0);
                end else begin
                    check("done_count", 32'(count), 32'(exp_q[0].val));
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit lm, input bit d, input int a, input logic [NREGS-1:0] lst);
        list_mode = lm;
        dir       = d;
        addr      = ADDR_W'(a);
        reg_list  = lst;
        start     = 1'b1;
        push_expect(lm, d, a, lst);
        tick();
        start = 1'b0;
    endtask

    // Bounded wait until the DUT is back in IDLE; optionally randomise L/step.
    task automatic wait_idle(input bit rnd);
        int n = 0;
        while ((busy || done) && n < 300) begin
            if (rnd) begin
                L    = ($urandom_range(0, 9) < 8);
                step = ($urandom_range(0, 9) < 6);
                if ($urandom_range(0, 7) == 0) reg_list = NREGS'($urandom);
                if ($urandom_range(0, 7) == 0) start = 1'b1;
            end
            tick();
            start = 1'b0;
            n++;
        end
        if (n >= 300) check("timeout_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; list_mode = 1'b0; dir = 1'b0;
        addr = '0; reg_list = '0; L = 1'b1; step = 1'b0;
        repeat (3) tick();
        check("rst_e", 32'(E), 32'd0);
        check("rst_busy_done", {busy, done}, 32'd0);
        check("rst_count_idx", {count, idx}, 32'd0);
        reset = 1'b0;
        tick();

        // 1: single mode, step held high.
        step = 1'b1; L = 1'b1;
        issue(1'b0, 1'b0, 10, '0);
        check("t1_e_at_t1", 32'(E), 32'h0400);
        check("t1_idx_at_t1", 32'(idx), 32'd10);
        tick();
        check("t1_done_at_t2", 32'(done), 32'd1);
        check("t1_count", 32'(count), 32'd1);
        wait_idle(1'b0);

        // 2 and 3: ascending and descending list walks.
        issue(1'b1, 1'b0, 0, 16'h8011);
        check("t2_first_e", 32'(E), 32'h0001);
        wait_idle(1'b0);
        check("t2_count", 32'(count), 32'd3);
        issue(1'b1, 1'b1, 0, 16'h8011);
        check("t3_first_idx", 32'(idx), 32'd15);
        wait_idle(1'b0);
        check("t3_count", 32'(count), 32'd3);

        // 4: stall by step=0 then L=0.
        step = 1'b0;
        issue(1'b1, 1'b0, 0, 16'h0006);
        tick(); tick();
        check("t4_e_holds", 32'(E), 32'h0002);
        L = 1'b0;
        repeat (3) tick();
        check("t4_e_zero_l_low", 32'(E), 32'd0);
        check("t4_still_busy", 32'(busy), 32'd1);
        L = 1'b1;
        tick();
        step = 1'b1;
        wait_idle(1'b0);
        check("t4_count", 32'(count), 32'd2);

        // 5: empty list; then start pulsed while busy is ignored.
        issue(1'b1, 1'b0, 0, 16'h0000);
        check("t5_done_at_t1", 32'(done), 32'd1);
        check("t5_e_zero", 32'(E), 32'd0);
        check("t5_count", 32'(count), 32'd0);
        tick();
        step = 1'b0;
        issue(1'b1, 1'b1, 0, 16'h0300);
        reg_list = 16'h00F0;
        start = 1'b1;
        tick();
        start = 1'b0;
        step = 1'b1;
        wait_idle(1'b0);
        check("t5_ignored_start_count", 32'(count), 32'd2);

        // 6: reset after one of four bits, then a full 16-register list.
        issue(1'b1, 1'b0, 0, 16'h000F);
        tick();
        reset = 1'b1; step = 1'b0;
        tick();
        exp_q.delete();
        check("t6_reset_e", 32'(E), 32'd0);
        check("t6_reset_busy_done", {busy, done}, 32'd0);
        reset = 1'b0;
        repeat (2) tick();
        check("t6_no_done", 32'(done), 32'd0);
        step = 1'b1;
        issue(1'b1, 1'b0, 0, 16'hFFFF);
        wait_idle(1'b0);
        check("t6_count16", 32'(count), 32'd16);

        // Random operations with random L/step, list changes and stray starts.
        for (int k = 0; k < 40; k++) begin
            logic [NREGS-1:0] lst;
            case ($urandom_range(0, 5))
                0: lst = '0;
                1: lst = '1;
                default: lst = NREGS'($urandom);
            endcase
            L    = ($urandom_range(0, 9) < 8);
            step = $urandom_range(0, 1);
            issue($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, NREGS - 1), lst);
            wait_idle(1'b1);
            tick();
        end

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_reg_list_decoder_seq
